// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the arbiter and the memory.
// The arbiter takes the slave side; the core and the memory model take the master side.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BW = DATA_WIDTH / 8;

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  ls_req;
    logic                  ls_we;
    logic [BW-1:0]         ls_be;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic                  ls_gnt;
    logic                  ls_rvalid;
    logic [DATA_WIDTH-1:0] ls_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [BW-1:0]         mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and
// load/store: one transaction at a time, fixed memory latency, response to the owner.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(MEM_LATENCY + 1);

    generate
        if (MEM_LATENCY < 1) begin : g_latency_check
            $error("mem_port_arbiter: MEM_LATENCY must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  last_ls;
    logic                  own_ls;
    logic                  own_we;
    logic                  gnt_if, gnt_ls;

    logic                  mem_en, mem_we;
    logic [BW-1:0]         mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  if_rvalid, ls_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata, ls_rdata;

    // Grants are combinational so the requester sees acceptance in the cycle it asks.
    // On a tie the port not served last wins; last_ls resets low so LS wins the first tie.
    always_comb begin
        gnt_if = 1'b0;
        gnt_ls = 1'b0;
        if (state == IDLE && !rst) begin
            if (bus.ls_req && (!bus.if_req || !last_ls))
                gnt_ls = 1'b1;
            else if (bus.if_req)
                gnt_if = 1'b1;
        end
    end

    // The command registers double as the latched request: loaded at grant,
    // presented for the single ISSUE cycle, then cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last_ls   <= 1'b0;
            own_ls    <= 1'b0;
            own_we    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_if || gnt_ls) begin
                        own_ls    <= gnt_ls;
                        last_ls   <= gnt_ls;
                        own_we    <= gnt_ls && bus.ls_we;
                        mem_en    <= 1'b1;
                        mem_we    <= gnt_ls && bus.ls_we;
                        mem_be    <= (gnt_ls && bus.ls_we) ? bus.ls_be : {BW{1'b1}};
                        mem_addr  <= gnt_ls ? bus.ls_addr : bus.if_addr;
                        mem_wdata <= gnt_ls ? bus.ls_wdata : '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_be    <= '0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    cnt       <= CW'(1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnt == CW'(MEM_LATENCY)) begin
                        if (!own_we) begin
                            if (own_ls) ls_rdata <= bus.mem_rdata;
                            else        if_rdata <= bus.mem_rdata;
                        end
                        ls_rvalid <= own_ls;
                        if_rvalid <= !own_ls;
                        cnt       <= '0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if_rvalid <= 1'b0;
                    ls_rvalid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.if_gnt    = gnt_if;
    assign bus.ls_gnt    = gnt_ls;
    assign bus.if_rvalid = if_rvalid;
    assign bus.ls_rvalid = ls_rvalid;
    assign bus.if_rdata  = if_rdata;
    assign bus.ls_rdata  = ls_rdata;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_be    = mem_be;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences, latency sweep,
// and random traffic checked every cycle by a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32, BW = DW / 8, L = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0, miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus4 ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));
    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) u1  (.clk(clk), .rst(rst), .bus(bus1));
    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(4)) u4  (.clk(clk), .rst(rst), .bus(bus4));

    // Sweep memories return a cycle-stamped word, so the captured value reveals the sample cycle.
    assign bus1.mem_rdata = 32'hA100_0000 + 32'(cyc);
    assign bus4.mem_rdata = 32'hA400_0000 + 32'(cyc);

    typedef struct {
        logic          ir;
        logic [AW-1:0] ia;
        logic          lr, lwe;
        logic [BW-1:0] lbe;
        logic [AW-1:0] la;
        logic [DW-1:0] lwd, mrd;
        logic          eig, elg, ewe;
        logic [BW-1:0] ebe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd, eird, elrd;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [159:0] outs();
        return {bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.if_rdata, bus.ls_rdata,
                bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
    endfunction

    // Reference model: a transaction occupies t = 0 (grant) .. L+2 (response); free again at L+3.
    logic          m_busy, m_ls, m_last_ls, m_we;
    int            m_t;
    logic [BW-1:0] m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rd, m_ls_rd;

    always @(negedge clk) begin
        logic eg_if, eg_ls, resp;
        if (rst) begin
            m_busy = 1'b0; m_last_ls = 1'b0; m_if_rd = '0; m_ls_rd = '0; m_t = 0;
            chk("model_reset_outs", outs(), '0);
        end else begin
            if (m_busy) begin
                m_t++;
                if (m_t == L + 3) m_busy = 1'b0;
            end
            eg_if = 1'b0; eg_ls = 1'b0;
            if (!m_busy) begin
                if (bus.ls_req && (!bus.if_req || !m_last_ls)) eg_ls = 1'b1;
                else if (bus.if_req)                           eg_if = 1'b1;
            end
            resp = m_busy && (m_t == L + 2);
            chk("model_gnt", {bus.if_gnt, bus.ls_gnt}, {eg_if, eg_ls});
            chk("model_mem", {bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata},
                (m_busy && m_t == 1) ? {1'b1, m_we, m_be, m_addr, m_wdata} : 70'd0);
            chk("model_rvalid", {bus.if_rvalid, bus.ls_rvalid}, {resp && !m_ls, resp && m_ls});
            chk("model_rdata", {bus.if_rdata, bus.ls_rdata}, {m_if_rd, m_ls_rd});
            if (m_busy && m_t == L + 1 && !m_we) begin
                if (m_ls) m_ls_rd = bus.mem_rdata;
                else      m_if_rd = bus.mem_rdata;
            end
            if (eg_if || eg_ls) begin
                m_busy    = 1'b1;
                m_t       = 0;
                m_ls      = eg_ls;
                m_last_ls = eg_ls;
                m_we      = eg_ls && bus.ls_we;
                m_be      = m_we ? bus.ls_be : {BW{1'b1}};
                m_addr    = eg_ls ? bus.ls_addr : bus.if_addr;
                m_wdata   = eg_ls ? bus.ls_wdata : '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_be = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        idle();
        @(negedge clk);
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic ifg, lsg;
        int   n, r1, r4, c0;
        int   got [6];
        logic [DW-1:0] d1, d4;

        idle();
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.ls_req = 1'b0; bus1.ls_we = 1'b0;
        bus1.ls_be = '0; bus1.ls_addr = '0; bus1.ls_wdata = '0;
        bus4.if_req = 1'b0; bus4.if_addr = '0; bus4.ls_req = 1'b0; bus4.ls_we = 1'b0;
        bus4.ls_be = '0; bus4.ls_addr = '0; bus4.ls_wdata = '0;

        tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF,
                   1'b1, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h200, 32'h12345678, 32'h55555555,
                   1'b0, 1'b1, 1'b1, 4'b0011, 32'h200, 32'h12345678, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h304, 32'hAAAA0000, 32'hCAFEF00D,
                   1'b0, 1'b1, 1'b0, 4'hF, 32'h304, 32'hAAAA0000, 32'hDEADBEEF, 32'hCAFEF00D};
        tbl[3] = '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0BADF00D,
                   1'b1, 1'b0, 1'b0, 4'hF, 32'hFFFFFFFC, 32'h0, 32'h0BADF00D, 32'hCAFEF00D};
        tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'b1000, 32'h10, 32'hFFFFFFFF, 32'h11111111,
                   1'b0, 1'b1, 1'b1, 4'h8, 32'h10, 32'hFFFFFFFF, 32'h0BADF00D, 32'hCAFEF00D};

        @(negedge clk);
        chk("reset_state", outs(), '0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            bus.if_req = tbl[i].ir; bus.if_addr = tbl[i].ia;
            bus.ls_req = tbl[i].lr; bus.ls_we = tbl[i].lwe; bus.ls_be = tbl[i].lbe;
            bus.ls_addr = tbl[i].la; bus.ls_wdata = tbl[i].lwd; bus.mem_rdata = tbl[i].mrd;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), {bus.if_gnt, bus.ls_gnt}, {tbl[i].eig, tbl[i].elg});
            step();
            bus.if_req = 1'b0; bus.ls_req = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d_mem", i), {bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata},
                {1'b1, tbl[i].ewe, tbl[i].ebe, tbl[i].ea, tbl[i].ewd});
            step(); step();
            @(negedge clk);
            chk($sformatf("tbl%0d_rvalid_c3", i), {bus.if_rvalid, bus.ls_rvalid}, 2'b00);
            step();
            @(negedge clk);
            chk($sformatf("tbl%0d_rvalid_c4", i), {bus.if_rvalid, bus.ls_rvalid}, {tbl[i].eig, tbl[i].elg});
            chk($sformatf("tbl%0d_rdata", i), {bus.if_rdata, bus.ls_rdata}, {tbl[i].eird, tbl[i].elrd});
            step();
            @(negedge clk);
            chk($sformatf("tbl%0d_rvalid_c5", i), {bus.if_rvalid, bus.ls_rvalid}, 2'b00);
        end

        // Reset in the WAIT phase of a fetch drops the transaction entirely.
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h40; bus.mem_rdata = 32'h77777777;
        @(negedge clk);
        chk("rstw_gnt", bus.if_gnt, 1'b1);
        step(); bus.if_req = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_outs_zero", outs(), '0);
        step(); rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rstw_no_rvalid", {bus.if_rvalid, bus.ls_rvalid}, 2'b00);
            step();
        end
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        @(negedge clk);
        chk("rstw_regnt", bus.if_gnt, 1'b1);
        step(); bus.if_req = 1'b0;
        step(); step(); step();
        @(negedge clk);
        chk("rstw_resp", {bus.if_rvalid, bus.if_rdata}, {1'b1, 32'h77777777});

        // First tie after reset goes to LS; IF stays pending and is served next.
        do_reset();
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h600; bus.mem_rdata = 32'h13579BDF;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) step();
            if (c == 1) bus.ls_req = 1'b0;
            if (c == 6) bus.if_req = 1'b0;
            @(negedge clk);
            case (c)
                0: chk("tie_gnt_c0", {bus.if_gnt, bus.ls_gnt}, 2'b01);
                4: chk("tie_ls_rvalid_c4", {bus.if_rvalid, bus.ls_rvalid}, 2'b01);
                5: chk("tie_if_gnt_c5", {bus.if_gnt, bus.ls_gnt}, 2'b10);
                9: chk("tie_if_rvalid_c9", {bus.if_rvalid, bus.ls_rvalid}, 2'b10);
                default: ;
            endcase
        end

        // Both held high: grants alternate starting with LS.
        do_reset();
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h700;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h800;
        n = 0;
        for (int i = 0; i < 6; i++) got[i] = 2;
        for (int k = 0; k < 100 && n < 6; k++) begin
            if (k > 0) step();
            @(negedge clk);
            if (bus.ls_gnt)      begin got[n] = 1; n++; end
            else if (bus.if_gnt) begin got[n] = 0; n++; end
        end
        chk("fair_grant_count", n, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("fair_grant%0d_is_ls", i), got[i], (i % 2 == 0) ? 1 : 0);
        step(); idle();

        // Latency sweep on the L=1 and L=4 instances.
        step();
        bus1.if_req = 1'b1; bus1.if_addr = 32'h80;
        bus4.if_req = 1'b1; bus4.if_addr = 32'h84;
        c0 = cyc;
        @(negedge clk);
        chk("lat_gnt", {bus1.if_gnt, bus4.if_gnt}, 2'b11);
        step();
        bus1.if_req = 1'b0; bus4.if_req = 1'b0;
        r1 = -1; r4 = -1; d1 = '0; d4 = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) step();
            @(negedge clk);
            if (bus1.if_rvalid && r1 < 0) begin r1 = k; d1 = bus1.if_rdata; end
            if (bus4.if_rvalid && r4 < 0) begin r4 = k; d4 = bus4.if_rdata; end
        end
        chk("lat1_rvalid_cycle", r1, 3);
        chk("lat1_rdata", d1, 32'hA100_0000 + 32'(c0 + 2));
        chk("lat4_rvalid_cycle", r4, 6);
        chk("lat4_rdata", d4, 32'hA400_0000 + 32'(c0 + 5));

        // Random traffic with occasional resets; the model checks every cycle.
        do_reset();
        ifg = 1'b0; lsg = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            step();
            rst = ($urandom_range(0, 149) == 0);
            if (!bus.if_req || ifg) begin
                bus.if_req  = 1'($urandom_range(0, 1));
                bus.if_addr = $urandom;
            end
            if (!bus.ls_req || lsg) begin
                bus.ls_req   = 1'($urandom_range(0, 1));
                bus.ls_we    = 1'($urandom_range(0, 1));
                bus.ls_be    = BW'($urandom);
                bus.ls_addr  = $urandom;
                bus.ls_wdata = $urandom;
            end
            bus.mem_rdata = $urandom;
            @(negedge clk);
            ifg = bus.if_gnt;
            lsg = bus.ls_gnt;
        end
        step();
        rst = 1'b0;
        idle();
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
